// File: rtl/spi_mem_pkg.sv
// ============================================================================
// Module      : spi_mem_pkg
// Description : Shared constants, state encoding and frame builder for the
//               SPI serial-SRAM controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_mem_pkg;

    localparam int ADDR_W     = 24;
    localparam int DATA_W     = 16;
    localparam int FRAME_BITS = 48;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        DONE  = 3'd2,
        GAP   = 3'd3,
        HOLD  = 3'd4
    } state_t;

    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic              wr,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata
    );
        return {wr ? CMD_WRITE : CMD_READ, addr, wr ? wdata : {DATA_W{1'b0}}};
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_mem_clkgen.sv
// ============================================================================
// Module      : spi_mem_clkgen
// Description : SPI mode-0 clock generator. Emits one-cycle rise/fall strobes
//               every CLK_DIV system clocks while enabled; parks low otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_mem_clkgen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_rise,
    output logic o_fall,
    output logic o_sclk
);

    localparam int c_PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [c_PH_W-1:0] r_phase;
    logic [c_PH_W-1:0] w_phase_d;
    logic              r_sclk;
    logic              w_sclk_d;
    logic              w_term;

    always_comb begin
        w_term    = (r_phase == c_PH_W'(CLK_DIV - 1));
        o_rise    = i_en && w_term && !r_sclk;
        o_fall    = i_en && w_term && r_sclk;
        w_phase_d = '0;
        w_sclk_d  = 1'b0;
        if (i_en) begin
            w_phase_d = w_term ? '0 : r_phase + c_PH_W'(1);
            w_sclk_d  = w_term ? !r_sclk : r_sclk;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
            r_sclk  <= 1'b0;
        end else begin
            r_phase <= w_phase_d;
            r_sclk  <= w_sclk_d;
        end
    end

    assign o_sclk = r_sclk;

endmodule

`default_nettype wire

// File: rtl/spi_mem_ctrl.sv
// ============================================================================
// Module      : spi_mem_ctrl
// Description : SPI initiator turning CPU requests into 16-bit 23LC-style
//               read/write frames. Define SPI_MEM_SEQ_EN to keep select
//               asserted after a transfer so a follow-on word at addr+2 can
//               be moved with a data-only frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_mem_ctrl
    import spi_mem_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy,
    output logic              spi_select,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

`ifdef SPI_MEM_SEQ_EN
    localparam bit c_SEQ_EN = 1'b1;
`else
    localparam bit c_SEQ_EN = 1'b0;
`endif

    localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t                  r_state,  w_state_d;
    logic [FRAME_BITS-1:0]   r_tx,     w_tx_d;
    logic [DATA_W-1:0]       r_rx,     w_rx_d;
    logic [5:0]              r_bits,   w_bits_d;
    logic                    r_short,  w_short_d;
    logic                    r_write,  w_write_d;
    logic [ADDR_W-1:0]       r_addr,   w_addr_d;
    logic [DATA_W-1:0]       r_wdata,  w_wdata_d;
    logic                    r_pend,   w_pend_d;
    logic [c_GAP_W-1:0]      r_gap,    w_gap_d;
    logic [3:0]              r_hold,   w_hold_d;
    logic                    r_sel,    w_sel_d;
    logic                    r_ready,  w_ready_d;
    logic                    r_resp,   w_resp_d;
    logic [DATA_W-1:0]       r_rdata,  w_rdata_d;

    logic w_accept;
    logic w_seq_hit;
    logic w_rise;
    logic w_fall;

    spi_mem_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_state == SHIFT),
        .o_rise (w_rise),
        .o_fall (w_fall),
        .o_sclk (spi_clk)
    );

    always_comb begin
        w_state_d = r_state;
        w_tx_d    = r_tx;
        w_rx_d    = r_rx;
        w_bits_d  = r_bits;
        w_short_d = r_short;
        w_write_d = r_write;
        w_addr_d  = r_addr;
        w_wdata_d = r_wdata;
        w_pend_d  = r_pend;
        w_gap_d   = r_gap;
        w_hold_d  = r_hold;
        w_sel_d   = r_sel;
        w_resp_d  = 1'b0;
        w_rdata_d = r_rdata;
        w_accept  = req_valid && r_ready;
        w_seq_hit = (req_write == r_write) && (req_addr == r_addr + ADDR_W'(2));

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_write_d = req_write;
                    w_addr_d  = req_addr;
                    w_wdata_d = req_wdata;
                    w_tx_d    = build_frame(req_write, req_addr, req_wdata);
                    w_bits_d  = '0;
                    w_short_d = 1'b0;
                    w_sel_d   = 1'b1;
                    w_state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (w_rise) begin
                    w_rx_d = {r_rx[DATA_W-2:0], spi_miso};
                end
                if (w_fall) begin
                    w_tx_d   = {r_tx[FRAME_BITS-2:0], 1'b0};
                    w_bits_d = r_bits + 6'd1;
                    if (r_bits == (r_short ? 6'd15 : 6'd47)) begin
                        w_bits_d  = '0;
                        w_sel_d   = c_SEQ_EN;
                        w_resp_d  = 1'b1;
                        w_rdata_d = r_write ? '0 : r_rx;
                        w_state_d = DONE;
                    end
                end
            end
            DONE: begin
                w_gap_d   = '0;
                w_hold_d  = '0;
                w_state_d = c_SEQ_EN ? HOLD : GAP;
            end
            GAP: begin
                w_gap_d = r_gap + c_GAP_W'(1);
                if (r_gap == c_GAP_W'(GAP_CYCLES - 1)) begin
                    w_gap_d = '0;
                    if (r_pend) begin
                        // Request accepted in HOLD that could not chain
                        w_pend_d  = 1'b0;
                        w_tx_d    = build_frame(r_write, r_addr, r_wdata);
                        w_bits_d  = '0;
                        w_short_d = 1'b0;
                        w_sel_d   = 1'b1;
                        w_state_d = SHIFT;
                    end else begin
                        w_state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                w_hold_d = r_hold + 4'd1;
                if (w_accept) begin
                    w_write_d = req_write;
                    w_addr_d  = req_addr;
                    w_wdata_d = req_wdata;
                    w_gap_d   = '0;
                    if (w_seq_hit) begin
                        w_tx_d    = {req_write ? req_wdata : {DATA_W{1'b0}}, 32'h0};
                        w_bits_d  = '0;
                        w_short_d = 1'b1;
                        w_state_d = SHIFT;
                    end else begin
                        w_pend_d  = 1'b1;
                        w_sel_d   = 1'b0;
                        w_state_d = GAP;
                    end
                end else if (r_hold == 4'd15) begin
                    w_gap_d   = '0;
                    w_sel_d   = 1'b0;
                    w_state_d = GAP;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_sel_d   = 1'b0;
            end
        endcase

        w_ready_d = (w_state_d == IDLE) || (w_state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_tx    <= '0;
            r_rx    <= '0;
            r_bits  <= '0;
            r_short <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_pend  <= 1'b0;
            r_gap   <= '0;
            r_hold  <= '0;
            r_sel   <= 1'b0;
            r_ready <= 1'b0;
            r_resp  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_d;
            r_tx    <= w_tx_d;
            r_rx    <= w_rx_d;
            r_bits  <= w_bits_d;
            r_short <= w_short_d;
            r_write <= w_write_d;
            r_addr  <= w_addr_d;
            r_wdata <= w_wdata_d;
            r_pend  <= w_pend_d;
            r_gap   <= w_gap_d;
            r_hold  <= w_hold_d;
            r_sel   <= w_sel_d;
            r_ready <= w_ready_d;
            r_resp  <= w_resp_d;
            r_rdata <= w_rdata_d;
        end
    end

    assign req_ready  = r_ready;
    assign resp_valid = r_resp;
    assign resp_rdata = r_rdata;
    assign busy       = (r_state != IDLE);
    assign spi_select = r_sel;
    assign spi_mosi   = r_tx[FRAME_BITS-1];

endmodule

`default_nettype wire

// File: tb/tb_spi_mem_ctrl.sv
// ============================================================================
// Module      : tb_spi_mem_ctrl
// Description : Self-checking bench for spi_mem_ctrl with a serial-SRAM
//               responder and a cycle-level behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_mem_ctrl;

    localparam int TB_CLK_DIV = 2;
    localparam int TB_GAP     = 2;
    localparam int C_SH       = 96 * TB_CLK_DIV;
    localparam int C_END      = C_SH + 1 + TB_GAP;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [23:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        spi_miso = 1'b0;
    logic        req_ready;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        busy;
    logic        spi_select;
    logic        spi_clk;
    logic        spi_mosi;

    spi_mem_ctrl #(
        .CLK_DIV    (TB_CLK_DIV),
        .GAP_CYCLES (TB_GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .busy       (busy),
        .spi_select (spi_select),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int n_resp   = 0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: unwritten bytes take a deterministic address-derived value.
    logic [7:0] sram    [logic [23:0]];
    logic [7:0] ref_mem [logic [23:0]];

    function automatic logic [7:0] dflt(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] sram_rd(input logic [23:0] a);
        return sram.exists(a) ? sram[a] : dflt(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [23:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Reference model: cycle position within the current transaction.
    logic        rst_last = 1'b1;
    bit          m_active = 1'b0;
    int          m_t      = 0;
    logic [47:0] m_frame  = '0;
    logic [15:0] m_exp_rd = '0;

    always @(posedge clk) rst_last <= rst;

    always @(negedge clk) begin
        bit   e_sel;
        bit   e_sclk;
        logic e_mosi;
        if (rst_last) begin
            m_active = 1'b0;
            chk("rst_ready", req_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_select", spi_select, 0);
            chk("rst_sclk", spi_clk, 0);
            chk("rst_mosi", spi_mosi, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_rdata", resp_rdata, 0);
        end else begin
            if (m_active) begin
                m_t++;
                if (m_t > C_END) m_active = 1'b0;
            end
            e_sel  = m_active && (m_t <= C_SH);
            e_sclk = e_sel && ((((m_t - 1) / TB_CLK_DIV) % 2) == 1);
            e_mosi = e_sel ? m_frame[47 - ((m_t - 1) / (2 * TB_CLK_DIV))] : 1'b0;
            chk("ready", req_ready, !m_active);
            chk("busy", busy, m_active);
            chk("select", spi_select, e_sel);
            chk("sclk", spi_clk, e_sclk);
            chk("mosi", spi_mosi, e_mosi);
            chk("resp_valid", resp_valid, m_active && (m_t == C_SH + 1));
            if (m_active && (m_t == C_SH + 1)) chk("resp_rdata", resp_rdata, m_exp_rd);
            if (!m_active && req_valid) begin
                m_active = 1'b1;
                m_t      = 0;
                m_frame  = {req_write ? 8'h02 : 8'h03, req_addr, req_write ? req_wdata : 16'h0};
                if (req_write) begin
                    m_exp_rd = 16'h0;
                    ref_mem[req_addr]          = req_wdata[15:8];
                    ref_mem[req_addr + 24'd1]  = req_wdata[7:0];
                end else begin
                    m_exp_rd = {ref_rd(req_addr), ref_rd(req_addr + 24'd1)};
                end
            end
        end
        if (resp_valid) n_resp++;
    end

    // Serial SRAM responder: 23LC framing, sequential while select stays high.
    int          nb = 0;
    logic [31:0] hdr = '0;
    logic [15:0] din = '0;
    logic [15:0] dout = '0;
    logic [23:0] raddr = '0;

    always @(posedge spi_select) nb = 0;

    always @(posedge spi_clk) begin
        if (spi_select) begin
            if (nb < 32) hdr = {hdr[30:0], spi_mosi};
            else         din = {din[14:0], spi_mosi};
            nb++;
            if (nb == 32) begin
                chk("frame_header", hdr, m_frame[47:16]);
                raddr = hdr[23:0];
            end
            if (nb >= 48 && ((nb - 32) % 16) == 0) begin
                if (hdr[31:24] == 8'h02) begin
                    chk("frame_wdata", din, m_frame[15:0]);
                    sram[raddr]         = din[15:8];
                    sram[raddr + 24'd1] = din[7:0];
                end
                raddr = raddr + 24'd2;
            end
        end
    end

    always @(negedge spi_clk) begin
        int k;
        if (spi_select && nb >= 32 && hdr[31:24] == 8'h03) begin
            k = (nb - 32) % 16;
            if (k == 0) dout = {sram_rd(raddr), sram_rd(raddr + 24'd1)};
            spi_miso = dout[15 - k];
        end
    end

    task automatic do_req(input logic w, input logic [23:0] a, input logic [15:0] d, input bit keep);
        bit ok = 1'b0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready;
            @(posedge clk);
            #1;
        end
        chk("accept_seen", ok, 1);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat, output logic [15:0] rd);
        bit seen = 1'b0;
        lat = 0;
        rd  = '0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (resp_valid) begin
                seen = 1'b1;
                rd   = resp_rdata;
            end
        end
        chk("resp_seen", seen, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          n0;
        logic [15:0] rd;
        sram[24'h10]    = 8'hBE;  sram[24'h11]    = 8'hEF;
        ref_mem[24'h10] = 8'hBE;  ref_mem[24'h11] = 8'hEF;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        do_req(1'b0, 24'h000010, 16'h0, 1'b0);
        wait_resp(lat, rd);
        chk("read_latency", lat, 193);
        chk("read_beef", rd, 16'hBEEF);

        do_req(1'b1, 24'h000020, 16'h1234, 1'b0);
        wait_resp(lat, rd);
        chk("write_rdata_zero", rd, 16'h0000);
        do_req(1'b0, 24'h000020, 16'h0, 1'b0);
        wait_resp(lat, rd);
        chk("readback_1234", rd, 16'h1234);

        n0 = n_resp;
        do_req(1'b1, 24'h000031, 16'hA5C3, 1'b1);
        do_req(1'b0, 24'h000031, 16'hFFFF, 1'b0);
        repeat (500) @(posedge clk);
        #1;
        chk("b2b_resp_count", n_resp - n0, 2);

        do_req(1'b0, 24'h000010, 16'h0, 1'b0);
        repeat (20 * 2 * TB_CLK_DIV) @(posedge clk);
        #1;
        n0  = n_resp;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("abort_no_resp", n_resp - n0, 0);
        do_req(1'b0, 24'h000010, 16'h0, 1'b0);
        wait_resp(lat, rd);
        chk("after_abort_beef", rd, 16'hBEEF);

        for (int i = 0; i < 30; i++) begin
            logic        w;
            logic [23:0] a;
            logic [15:0] d;
            bit          keep;
            w    = 1'($urandom_range(0, 1));
            a    = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom_range(0, 40));
            d    = 16'($urandom);
            keep = ($urandom_range(0, 2) == 0);
            do_req(w, a, d, keep);
            if (!keep) begin
                if ($urandom_range(0, 1) == 1) wait_resp(lat, rd);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        req_valid = 1'b0;
        repeat (400) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
